vin_timing_detector: RTL

VIN_TIMING_DETECTOR -- requirements
Module: vin_timing_detector

---
 rtl/vin_timing_pkg.sv | 14 +
 rtl/sync_edge.sv | 32 +++
 rtl/vin_timing_detector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vin_timing_pkg.sv
// Shared definitions for the video input timing detector: lock FSM states
// and the default counter width.
package vin_timing_pkg;

  localparam int CW_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Registers a sync input once, normalises it to active-high and flags the
// cycle on which the registered level enters the active state.
module sync_edge #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic edge_o
);

  logic lvl_q, lvl_d;
  logic prev_q, prev_d;

  always_comb begin
    lvl_d  = (sig_i == POL);
    prev_d = lvl_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      prev_q <= prev_d;
    end
  end

  assign edge_o = lvl_q & ~prev_q;

endmodule

// File: rtl/vin_timing_detector.sv
// Measures incoming video timing (line/frame totals and active sizes), locks
// once two consecutive frames agree, and produces pixel coordinates for DE.
module vin_timing_detector
  import vin_timing_pkg::*;
#(
  parameter int CW     = CW_DEFAULT,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          de_i,
  output logic [CW-1:0] h_total_o,
  output logic [CW-1:0] h_active_o,
  output logic [CW-1:0] v_total_o,
  output logic [CW-1:0] v_active_o,
  output logic          locked_o,
  output logic          err_o,
  output logic          de_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          frame_start_o
);

  localparam logic [CW-1:0] ONES = {CW{1'b1}};
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic hs_edge_s, vs_edge_s;

  sync_edge #(.POL(HS_POL)) u_hs_edge (.clk(clk), .rst(rst), .sig_i(hs_i), .edge_o(hs_edge_s));
  sync_edge #(.POL(VS_POL)) u_vs_edge (.clk(clk), .rst(rst), .sig_i(vs_i), .edge_o(vs_edge_s));

  state_e        state_q, state_d;
  logic          de_q, de_d, line_valid_q, line_valid_d;
  logic [CW-1:0] hcnt_q, hcnt_d, line_len_q, line_len_d, line_de_q, line_de_d;
  logic [CW-1:0] hact_q, hact_d, vtot_q, vtot_d, vact_q, vact_d;
  logic [CW-1:0] cand_ht_q, cand_ht_d, cand_ha_q, cand_ha_d, cand_vt_q, cand_vt_d, cand_va_q, cand_va_d;
  logic [CW-1:0] pub_ht_q, pub_ht_d, pub_ha_q, pub_ha_d, pub_vt_q, pub_vt_d, pub_va_q, pub_va_d;
  logic          locked_q, locked_d, err_q, err_d, fs_q, fs_d, de_o_q, de_o_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;

  logic [CW-1:0] frm_ht_s, frm_ha_s, frm_vt_s, frm_va_s, x_s, y_s;
  logic          timeout_s, frame_bad_s, eq_cand_s, eq_pub_s;

  // An hs edge closes the running line before a coincident vs edge closes the frame.
  always_comb begin
    de_d      = de_i;
    timeout_s = ((hcnt_q == ONES) && !hs_edge_s) || ((vtot_q == ONES) && !vs_edge_s);
    hcnt_d    = hs_edge_s ? ONE : ((hcnt_q == ONES) ? ONES : hcnt_q + ONE);
    line_valid_d = timeout_s ? 1'b0 : (line_valid_q | hs_edge_s);

    frm_ht_s = (hs_edge_s && line_valid_q) ? hcnt_q : line_len_q;
    frm_ha_s = (hs_edge_s && (line_de_q > hact_q)) ? line_de_q : hact_q;
    frm_vt_s = (hs_edge_s && (vtot_q != ONES)) ? vtot_q + ONE : vtot_q;
    frm_va_s = (hs_edge_s && (line_de_q != ZERO) && (vact_q != ONES)) ? vact_q + ONE : vact_q;

    x_s        = hs_edge_s ? ZERO : line_de_q;
    y_s        = vs_edge_s ? ZERO : frm_va_s;
    line_de_d  = (de_q && (x_s != ONES)) ? x_s + ONE : x_s;
    line_len_d = frm_ht_s;

    if (vs_edge_s) begin
      hact_d = ZERO;
      vtot_d = ZERO;
      vact_d = ZERO;
    end else begin
      hact_d = frm_ha_s;
      vtot_d = frm_vt_s;
      vact_d = frm_va_s;
    end

    de_o_d = de_q;
    x_d    = de_q ? x_s : ZERO;
    y_d    = de_q ? y_s : ZERO;
  end

  // Saturated or empty measurements can never compare equal, so they never lock.
  always_comb begin
    frame_bad_s = (frm_ht_s == ONES) || (frm_ha_s == ONES) || (frm_vt_s == ONES) ||
                  (frm_va_s == ONES) || (frm_ha_s == ZERO) || (frm_va_s == ZERO);
    eq_cand_s = !frame_bad_s && ({frm_ht_s, frm_ha_s, frm_vt_s, frm_va_s} ==
                                 {cand_ht_q, cand_ha_q, cand_vt_q, cand_va_q});
    eq_pub_s  = !frame_bad_s && ({frm_ht_s, frm_ha_s, frm_vt_s, frm_va_s} ==
                                 {pub_ht_q, pub_ha_q, pub_vt_q, pub_va_q});

    state_d   = state_q;
    cand_ht_d = cand_ht_q;
    cand_ha_d = cand_ha_q;
    cand_vt_d = cand_vt_q;
    cand_va_d = cand_va_q;
    pub_ht_d  = pub_ht_q;
    pub_ha_d  = pub_ha_q;
    pub_vt_d  = pub_vt_q;
    pub_va_d  = pub_va_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    fs_d      = vs_edge_s && (state_q != ST_SEARCH);

    if (timeout_s) begin
      state_d  = ST_SEARCH;
      locked_d = 1'b0;
      err_d    = (state_q == ST_LOCKED);
    end else if (vs_edge_s) begin
      case (state_q)
        ST_SEARCH: begin
          state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          {cand_ht_d, cand_ha_d, cand_vt_d, cand_va_d} = {frm_ht_s, frm_ha_s, frm_vt_s, frm_va_s};
          state_d = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (eq_cand_s) begin
            {pub_ht_d, pub_ha_d, pub_vt_d, pub_va_d} = {frm_ht_s, frm_ha_s, frm_vt_s, frm_va_s};
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end else begin
            {cand_ht_d, cand_ha_d, cand_vt_d, cand_va_d} = {frm_ht_s, frm_ha_s, frm_vt_s, frm_va_s};
          end
        end
        ST_LOCKED: begin
          if (!eq_pub_s) begin
            {cand_ht_d, cand_ha_d, cand_vt_d, cand_va_d} = {frm_ht_s, frm_ha_s, frm_vt_s, frm_va_s};
            locked_d = 1'b0;
            err_d    = 1'b1;
            state_d  = ST_VERIFY;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SEARCH;
      de_q         <= 1'b0;
      line_valid_q <= 1'b0;
      hcnt_q       <= ZERO;
      line_len_q   <= ZERO;
      line_de_q    <= ZERO;
      hact_q       <= ZERO;
      vtot_q       <= ZERO;
      vact_q       <= ZERO;
      cand_ht_q    <= ZERO;
      cand_ha_q    <= ZERO;
      cand_vt_q    <= ZERO;
      cand_va_q    <= ZERO;
      pub_ht_q     <= ZERO;
      pub_ha_q     <= ZERO;
      pub_vt_q     <= ZERO;
      pub_va_q     <= ZERO;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      fs_q         <= 1'b0;
      de_o_q       <= 1'b0;
      x_q          <= ZERO;
      y_q          <= ZERO;
    end else begin
      state_q      <= state_d;
      de_q         <= de_d;
      line_valid_q <= line_valid_d;
      hcnt_q       <= hcnt_d;
      line_len_q   <= line_len_d;
      line_de_q    <= line_de_d;
      hact_q       <= hact_d;
      vtot_q       <= vtot_d;
      vact_q       <= vact_d;
      cand_ht_q    <= cand_ht_d;
      cand_ha_q    <= cand_ha_d;
      cand_vt_q    <= cand_vt_d;
      cand_va_q    <= cand_va_d;
      pub_ht_q     <= pub_ht_d;
      pub_ha_q     <= pub_ha_d;
      pub_vt_q     <= pub_vt_d;
      pub_va_q     <= pub_va_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      fs_q         <= fs_d;
      de_o_q       <= de_o_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  assign h_total_o     = pub_ht_q;
  assign h_active_o    = pub_ha_q;
  assign v_total_o     = pub_vt_q;
  assign v_active_o    = pub_va_q;
  assign locked_o      = locked_q;
  assign err_o         = err_q;
  assign frame_start_o = fs_q;
  assign de_o          = de_o_q;
  assign x_o           = x_q;
  assign y_o           = y_q;

endmodule
